// File: rtl/muu_input_arbiter_pkg.sv
// rtl/muu_input_arbiter_pkg.sv - shared muu definitions: arbiter states, default widths, opcodes
package muu_input_arbiter_pkg;

    localparam int MUU_DATA_WIDTH = 576;
    localparam int MUU_USER_BITS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PASS  = 2'd2
    } arb_state_e;

    typedef enum logic [3:0] {
        MUU_OP_NOP   = 4'd0,
        MUU_OP_LOAD  = 4'd1,
        MUU_OP_STORE = 4'd2,
        MUU_OP_MAC   = 4'd3,
        MUU_OP_FLUSH = 4'd4
    } muu_opcode_e;

endpackage

// File: rtl/muu_axis_skid.sv
// rtl/muu_axis_skid.sv - two-entry stream skid buffer with registered outputs
module muu_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_tready  = (count_q != 2'd2) || out_tready;
    assign out_tvalid = (count_q != 2'd0);
    assign out_tdata  = mem_q[rd_ptr_q];
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_tdata;
        end
    end

endmodule

// File: rtl/muu_input_arbiter.sv
// rtl/muu_input_arbiter.sv - packet-atomic round-robin merge of requester streams
module muu_input_arbiter
    import muu_input_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int USER_BITS  = MUU_USER_BITS,
    parameter int DATA_WIDTH = MUU_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_PORTS-1:0]            in_tvalid,
    input  logic [NUM_PORTS-1:0]            in_tlast,
    output logic [NUM_PORTS-1:0]            in_tready,
    input  logic [NUM_PORTS-1:0]            port_enable,
    output logic [DATA_WIDTH-1:0]           out_tdata,
    output logic                            out_tvalid,
    output logic                            out_tlast,
    input  logic                            out_tready,
    output logic [USER_BITS-1:0]            out_tuserid,
    output logic [31:0]                     pkt_count,
    output logic [3:0]                      _debug
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = DATA_WIDTH + 1 + USER_BITS;

    arb_state_e            state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic [31:0]           pkt_count_q;
    logic                  proto_err_q;
    logic                  wrap_err_q;
    logic                  pending_q;

    logic [NUM_PORTS-1:0]  req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  beat_valid;
    logic                  skid_ready;
    logic                  push;
    logic [SW-1:0]         skid_in;
    logic [SW-1:0]         skid_out;

    // First requester after 'last', wrapping; scanning downward lets the nearest one win.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        pick = last;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = GW'((int'(last) + k) % NUM_PORTS);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        req       = in_tvalid & port_enable;
        sel_valid = in_tvalid[grant_q];
        sel_last  = in_tlast[grant_q];
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        beat_valid = (state_q == ST_PASS) && sel_valid;
        push       = beat_valid && skid_ready;
        in_tready  = '0;
        if (state_q == ST_PASS) begin
            in_tready[grant_q] = skid_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            pkt_count_q  <= '0;
            proto_err_q  <= 1'b0;
            wrap_err_q   <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            // A beat offered but refused must stay offered until taken.
            pending_q <= beat_valid && !skid_ready;
            if (pending_q && (state_q == ST_PASS) && !sel_valid) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= rr_pick(req, last_grant_q);
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state_q <= ST_PASS;
                end
                ST_PASS: begin
                    if (push && sel_last) begin
                        last_grant_q <= grant_q;
                        pkt_count_q  <= pkt_count_q + 32'd1;
                        if (&pkt_count_q) begin
                            wrap_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign skid_in = {sel_data, sel_last, USER_BITS'(grant_q)};

    muu_axis_skid #(
        .WIDTH(SW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (skid_in),
        .in_tvalid  (beat_valid),
        .in_tready  (skid_ready),
        .out_tdata  (skid_out),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    assign {out_tdata, out_tlast, out_tuserid} = skid_out;
    assign pkt_count = pkt_count_q;
    assign _debug    = {state_q, wrap_err_q, proto_err_q};

endmodule
